classificador_face: RTL

//  Downstream consumer of the 3x3 sample-pixel RAM filled by the OV7670 capture datapath.
//  On request, reads the 9 RGB565 samples in order and classifies each into a Rubik colour code.

---
 rtl/classificador_face_pkg.sv | 34 +++
 rtl/classificador_cor.sv | 49 ++++
 rtl/classificador_face.sv | 132 +++++++++++++
 3 files changed

// File: rtl/classificador_face_pkg.sv
// Shared constants for the Rubik face classifier: colour codes, FSM encoding,
// face slot geometry and the 5-to-6 bit channel expansion helper.
package classificador_face_pkg;

    localparam int unsigned PIXEL_W = 16;
    localparam int unsigned CANAL_W = 6;
    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned N_SLOTS = 9;
    localparam int unsigned FACE_W  = SLOT_W * N_SLOTS;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned SLOT_IDX_W = 4;
    localparam int unsigned ESPERA_W   = 2;

    localparam logic [SLOT_W-1:0] COR_BRANCO   = 3'd0;
    localparam logic [SLOT_W-1:0] COR_AMARELO  = 3'd1;
    localparam logic [SLOT_W-1:0] COR_VERMELHO = 3'd2;
    localparam logic [SLOT_W-1:0] COR_LARANJA  = 3'd3;
    localparam logic [SLOT_W-1:0] COR_VERDE    = 3'd4;
    localparam logic [SLOT_W-1:0] COR_AZUL     = 3'd5;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECA = 3'd1,
        ESPERA   = 3'd2,
        GRAVA    = 3'd3,
        PUBLICA  = 3'd4
    } estado_t;

    // Replicate the channel MSB so 5-bit R/B scale onto the 6-bit G range.
    function automatic logic [CANAL_W-1:0] expande5(input logic [4:0] c);
        return {c, c[4]};
    endfunction

endpackage

// File: rtl/classificador_cor.sv
// Combinational RGB565 -> Rubik colour code classifier; rules are
// evaluated in priority order and the first match wins.
module classificador_cor
    import classificador_face_pkg::*;
#(
    parameter int unsigned LIMIAR_BRANCO = 40
) (
    input  logic [PIXEL_W-1:0] pixel,
    output logic [SLOT_W-1:0]  cor
);

    logic [CANAL_W-1:0] r6;
    logic [CANAL_W-1:0] g6;
    logic [CANAL_W-1:0] b6;
    logic [CANAL_W-1:0] minimo;
    logic [7:0]         g_x4;
    logic [7:0]         g_x3;
    logic [7:0]         r_x3;

    always_comb begin
        r6 = expande5(pixel[15:11]);
        g6 = pixel[10:5];
        b6 = expande5(pixel[4:0]);

        minimo = r6;
        if (g6 < minimo) minimo = g6;
        if (b6 < minimo) minimo = b6;

        // Products fit in 8 bits: 4*63 = 252, 3*63 = 189.
        g_x4 = {g6, 2'b00};
        g_x3 = 8'(g6) + {1'b0, g6, 1'b0};
        r_x3 = 8'(r6) + {1'b0, r6, 1'b0};

        if (minimo >= CANAL_W'(LIMIAR_BRANCO)) begin
            cor = COR_BRANCO;
        end else if (b6 >= r6 && b6 >= g6) begin
            cor = COR_AZUL;
        end else if (g6 > r6) begin
            cor = COR_VERDE;
        end else if (g_x4 >= r_x3) begin
            cor = COR_AMARELO;
        end else if (g_x3 >= 8'(r6)) begin
            cor = COR_LARANJA;
        end else begin
            cor = COR_VERMELHO;
        end
    end

endmodule

// File: rtl/classificador_face.sv
// Reads the 3x3 sample RAM line-major, classifies every pixel into a shadow
// buffer and publishes the 27-bit face word atomically with a pronto pulse.
module classificador_face
    import classificador_face_pkg::*;
#(
    parameter int unsigned S_DATA        = 16,
    parameter int unsigned LATENCIA_RAM  = 1,
    parameter int unsigned LIMIAR_BRANCO = 40
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [S_DATA-1:0]   pixel,
    output logic [ADDR_W-1:0]   addr_linha,
    output logic [ADDR_W-1:0]   addr_coluna,
    output logic                ocupado,
    output logic                pronto,
    output logic [FACE_W-1:0]   face,
    output logic                face_valida,
    output logic [SLOT_W-1:0]   centro
);

    estado_t               estado;
    estado_t               estado_next;
    logic [ADDR_W-1:0]     linha_next;
    logic [ADDR_W-1:0]     coluna_next;
    logic [ESPERA_W-1:0]   espera_cnt;
    logic [ESPERA_W-1:0]   espera_next;
    logic [FACE_W-1:0]     buffer;
    logic [FACE_W-1:0]     buffer_next;
    logic [FACE_W-1:0]     face_next;
    logic                  valida_next;
    logic                  pronto_next;
    logic                  ocupado_next;
    logic [SLOT_IDX_W-1:0] slot;
    logic [SLOT_W-1:0]     cor;

    classificador_cor #(
        .LIMIAR_BRANCO(LIMIAR_BRANCO)
    ) u_cor (
        .pixel(pixel[PIXEL_W-1:0]),
        .cor  (cor)
    );

    assign slot   = SLOT_IDX_W'(addr_linha) * SLOT_IDX_W'(3) + SLOT_IDX_W'(addr_coluna);
    assign centro = face[14:12];

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            addr_linha  <= '0;
            addr_coluna <= '0;
            espera_cnt  <= '0;
            buffer      <= '0;
            face        <= '0;
            face_valida <= 1'b0;
            pronto      <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            estado      <= estado_next;
            addr_linha  <= linha_next;
            addr_coluna <= coluna_next;
            espera_cnt  <= espera_next;
            buffer      <= buffer_next;
            face        <= face_next;
            face_valida <= valida_next;
            pronto      <= pronto_next;
            ocupado     <= ocupado_next;
        end
    end

    // Next-state and datapath updates; face is loaded together with the
    // final slot so it becomes visible in the same cycle as pronto.
    always_comb begin
        estado_next = estado;
        linha_next  = addr_linha;
        coluna_next = addr_coluna;
        espera_next = espera_cnt;
        buffer_next = buffer;
        face_next   = face;
        valida_next = face_valida;

        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    estado_next = ENDERECA;
                    linha_next  = '0;
                    coluna_next = '0;
                end
            end
            ENDERECA: begin
                estado_next = ESPERA;
                espera_next = ESPERA_W'(1);
            end
            ESPERA: begin
                if (espera_cnt == ESPERA_W'(LATENCIA_RAM)) begin
                    estado_next = GRAVA;
                end else begin
                    espera_next = espera_cnt + ESPERA_W'(1);
                end
            end
            GRAVA: begin
                buffer_next[SLOT_W*slot +: SLOT_W] = cor;
                if (slot == SLOT_IDX_W'(N_SLOTS - 1)) begin
                    estado_next = PUBLICA;
                    face_next   = buffer_next;
                    valida_next = 1'b1;
                end else begin
                    estado_next = ENDERECA;
                    if (addr_coluna == ADDR_W'(2)) begin
                        coluna_next = '0;
                        linha_next  = addr_linha + ADDR_W'(1);
                    end else begin
                        coluna_next = addr_coluna + ADDR_W'(1);
                    end
                end
            end
            PUBLICA: begin
                estado_next = OCIOSO;
                linha_next  = '0;
                coluna_next = '0;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase

        pronto_next  = (estado_next == PUBLICA);
        ocupado_next = (estado_next != OCIOSO);
    end

endmodule
